// File: rtl/demux_tree.sv
// demux_tree: 1-to-4 lane demultiplexer with an independent FIFO per lane.
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake; in_sel picks the lane, in_data is the payload
//   out_valid/out_ready  per-lane downstream handshake, one bit per lane
//   out_data             lane n at [n*DATA_W +: DATA_W], shows the lane FIFO head
//   lane_cnt             per-lane saturating accepted-word counters, lane n at [8n +: 8]
//                        (only when DEMUX_CNT_EN is defined)
// Optional feature macro: DEMUX_CNT_EN (default undefined: no lane_cnt port, no counters).

// Lane FIFO: DEPTH-entry circular buffer with an occupancy counter; head shown combinationally.
// Latency: a push into an empty FIFO is visible on o_vld/o_dat the next cycle.
// Backpressure: o_full refuses pushes; a pop on a full FIFO frees one slot for the following cycle.
module demux_lane_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push_vld,
   input  logic [DATA_W-1:0] i_push_dat,
   input  logic              i_pop_rdy,
   output logic              o_full,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_dat
);

   // DEPTH is 2 or 4, so natural pointer overflow is the modulo-DEPTH wrap.
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;

   logic w_push;
   logic w_pop;

   assign o_full = (r_cnt == CNT_W'(DEPTH));
   assign o_vld  = (r_cnt != '0);
   // Gate the head with o_vld so an empty lane always shows zero, including after reset.
   assign o_dat  = o_vld ? r_mem[r_rd_ptr] : '0;

   // A full FIFO never takes a push, even when it is popped in the same cycle.
   assign w_push = i_push_vld && !o_full;
   assign w_pop  = i_pop_rdy && o_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: the occupancy counter decides what is visible.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

endmodule

// Top: steers each accepted word into the FIFO of lane in_sel; four independent output lanes.
// Latency: a word accepted in cycle t appears on its lane in cycle t+1 when that lane was empty.
// Backpressure: in_ready reflects only the selected lane's fullness; stalled lanes never block others.
module demux_tree #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_sel,
   input  logic [DATA_W-1:0]   in_data,
   output logic [3:0]          out_valid,
   input  logic [3:0]          out_ready,
   output logic [4*DATA_W-1:0] out_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [31:0]         lane_cnt
`endif
);

   logic [3:0] w_full;
   logic [3:0] w_push_vld;

   // Combinational from in_sel and FIFO state only; in_valid does not feed it.
   assign in_ready = !w_full[in_sel];

   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign w_push_vld[g] = in_valid && (in_sel == 2'(g));

      demux_lane_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .rst        (rst),
         .i_push_vld (w_push_vld[g]),
         .i_push_dat (in_data),
         .i_pop_rdy  (out_ready[g]),
         .o_full     (w_full[g]),
         .o_vld      (out_valid[g]),
         .o_dat      (out_data[g*DATA_W +: DATA_W])
      );
   end

`ifdef DEMUX_CNT_EN
   logic [7:0] r_lane_cnt [4];

   for (genvar g = 0; g < 4; g++) begin : g_cnt
      // Counts the same transfers the FIFO accepts; holds at 255.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_lane_cnt[g] <= 8'd0;
         end else if (w_push_vld[g] && !w_full[g] && (r_lane_cnt[g] != 8'hFF)) begin
            r_lane_cnt[g] <= r_lane_cnt[g] + 8'd1;
         end
      end
      assign lane_cnt[8*g +: 8] = r_lane_cnt[g];
   end
`endif

endmodule

// File: tb/tb_demux_tree.sv
// Directed bench for demux_tree: routing, backpressure, lane isolation,
// simultaneous push/pop, mid-stream reset and (with DEMUX_CNT_EN) lane counters.
module tb_demux_tree;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [7:0]  in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
`ifdef DEMUX_CNT_EN
   logic [31:0] lane_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   demux_tree #(.DATA_W(8), .DEPTH(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DEMUX_CNT_EN
      ,
      .lane_cnt  (lane_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] sel, input logic [7:0] dat);
      in_valid = 1'b1;
      in_sel   = sel;
      in_data  = dat;
   endtask

   initial begin
      logic [7:0] route_dat [4];
      route_dat[0] = 8'h11; route_dat[1] = 8'h22; route_dat[2] = 8'h33; route_dat[3] = 8'h44;

      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'b0000;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_data", 64'(out_data), 64'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'h1);
      end

      // Routing: one word per lane on consecutive cycles, all lanes draining
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         push(2'(i), route_dat[i]);
         #1;
         check($sformatf("route_in_ready%0d", i), 64'(in_ready), 64'h1);
         step();
         check($sformatf("route_valid%0d", i), 64'(out_valid), 64'(4'b0001 << i));
         check($sformatf("route_data%0d", i), 64'(out_data[i*8 +: 8]), 64'(route_dat[i]));
      end
      in_valid = 1'b0;
      step();
      check("route_drained", 64'(out_valid), 64'h0);

      // Full / backpressure on lane 2
      out_ready = 4'b1011;
      push(2'd2, 8'hA0); #1;
      check("bp_rdy_w0", 64'(in_ready), 64'h1);
      step();
      push(2'd2, 8'hA1); #1;
      check("bp_rdy_w1", 64'(in_ready), 64'h1);
      step();
      push(2'd2, 8'hA2); #1;
      check("bp_rdy_full", 64'(in_ready), 64'h0);
      check("bp_valid", 64'(out_valid), 64'h4);
      check("bp_head0", 64'(out_data[23:16]), 64'hA0);
      step();
      check("bp_head_stable", 64'(out_data[23:16]), 64'hA0);
      check("bp_rdy_still_full", 64'(in_ready), 64'h0);
      out_ready = 4'b1111;
      step();
      check("bp_head1", 64'(out_data[23:16]), 64'hA1);
      check("bp_rdy_after_pop", 64'(in_ready), 64'h1);
      step();
      in_valid = 1'b0;
      check("bp_head2", 64'(out_data[23:16]), 64'hA2);
      check("bp_valid2", 64'(out_valid), 64'h4);
      step();
      check("bp_drained", 64'(out_valid), 64'h0);

      // Lane isolation: lane 1 full and stalled, lane 3 keeps flowing
      out_ready = 4'b1101;
      push(2'd1, 8'hB0); step();
      push(2'd1, 8'hB1); step();
      push(2'd1, 8'hB2); #1;
      check("iso_lane1_full", 64'(in_ready), 64'h0);
      for (int i = 0; i < 4; i++) begin
         push(2'd3, 8'(8'hC0 + i)); #1;
         check($sformatf("iso_rdy%0d", i), 64'(in_ready), 64'h1);
         step();
         check($sformatf("iso_l3_dat%0d", i), 64'(out_data[31:24]), 64'(8'hC0 + i));
         check($sformatf("iso_l1_head%0d", i), 64'(out_data[15:8]), 64'hB0);
      end
      in_valid = 1'b0;
      out_ready = 4'b1111;
      step();
      check("iso_l1_b1", 64'(out_data[15:8]), 64'hB1);
      check("iso_valid_b1", 64'(out_valid), 64'h2);
      step();
      check("iso_drained", 64'(out_valid), 64'h0);

      // Simultaneous push and pop on lane 0 holding one word
      out_ready = 4'b0000;
      push(2'd0, 8'h33); step();
      out_ready = 4'b0001;
      push(2'd0, 8'h5A); #1;
      check("pp_rdy", 64'(in_ready), 64'h1);
      step();
      in_valid = 1'b0;
      check("pp_head", 64'(out_data[7:0]), 64'h5A);
      check("pp_valid", 64'(out_valid), 64'h1);
      step();
      check("pp_occ_one", 64'(out_valid), 64'h0);

      // Reset mid-stream: lane 2 holds two words; a push to lane 1 during reset is dropped
      out_ready = 4'b0000;
      push(2'd2, 8'hD0); step();
      push(2'd2, 8'hD1); step();
      check("mr_valid_pre", 64'(out_valid), 64'h4);
      rst = 1'b1;
      push(2'd1, 8'hD2);
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      in_sel = 2'd2;
      #1;
      check("mr_valid", 64'(out_valid), 64'h0);
      check("mr_data", 64'(out_data), 64'h0);
      check("mr_rdy", 64'(in_ready), 64'h1);
      out_ready = 4'b1111;
      step();
      check("mr_no_old", 64'(out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
      out_ready = 4'b1111;
      push(2'd3, 8'hEE);
      for (int i = 0; i < 300; i++) step();
      in_valid = 1'b0;
      step();
      check("cnt_sat", 64'(lane_cnt), 64'hFF00_0000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt_rst", 64'(lane_cnt), 64'h0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/demux_tree.md
DEMUX_TREE -- requirements
Module: demux_tree

Interface
REQ-001 Parameter DATA_W, default 8, sets the payload width in bits.
REQ-002 Parameter DEPTH, default 2, sets the entries per lane FIFO; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_sel  input  2  destination lane; bit1=s1, bit0=s2; lane = {s1,s2}.
REQ-008 in_data  input  DATA_W  payload.
REQ-009 out_valid  output  4  per-lane word present.
REQ-010 out_ready  input  4  per-lane downstream accept.
REQ-011 out_data  output  4*DATA_W  lane n occupies bits [n*DATA_W +: DATA_W].
REQ-012 lane_cnt  output  32  four 8-bit accepted-word counters, lane n at bits [8n +: 8]; present only with DEMUX_CNT_EN.

Function
REQ-013 Input transfer occurs when in_valid && in_ready; the word is written to the FIFO of lane in_sel.
REQ-014 in_ready shall equal "FIFO of lane in_sel not full"; it is combinational from in_sel and the FIFO state and independent of in_valid.
REQ-015 Output transfer on lane n occurs when out_valid[n] && out_ready[n]; it pops the head of FIFO n.
REQ-016 out_valid[n] shall be high exactly when FIFO n is non-empty; out_data lane n shall show the FIFO n head and remain stable while out_valid[n] && !out_ready[n].
REQ-017 Latency: a word accepted in cycle t shall appear on its lane in cycle t+1 if that FIFO was empty.
REQ-018 Each lane FIFO is independent; a stalled lane shall never block acceptance for a different lane.
REQ-019 Words on a lane shall leave in acceptance order, with no loss and no duplication.
REQ-020 Full lane with a simultaneous push and pop: in_ready is low, so no push occurs; the pop proceeds.
REQ-021 Non-full, non-empty lane with a simultaneous push and pop: both occur and the occupancy is unchanged.
REQ-022 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy is a counter from 0 to DEPTH.
REQ-023 While in_valid is low, in_sel and in_data are don't-care and no state changes occur.

Reset
REQ-024 While rst is high at a clk edge, all FIFOs shall empty and the pointers and occupancies shall clear to 0.
REQ-025 Reset values: out_valid=4'b0000 and out_data=0; in_ready=1 for any in_sel after reset.
REQ-026 Reset mid-operation discards all buffered words; no input transfer occurs in a reset cycle.
REQ-027 Reset has priority over simultaneous push and pop.

Configuration
REQ-028 Macro DEMUX_CNT_EN.
- Defined: the lane_cnt port exists.
- Each counter increments on every input transfer to its lane.
- Counters saturate at 255.
- Counters clear on rst.
REQ-029 DEMUX_CNT_EN undefined: no lane_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-030 Routing: DATA_W=8, out_ready=4'b1111; send 0x11,0x22,0x33,0x44 with in_sel=0,1,2,3 on consecutive cycles -> each value appears on lane 0,1,2,3 respectively, one cycle after acceptance.
REQ-031 Full/backpressure: DEPTH=2, out_ready[2]=0; send 3 words to lane 2 -> in_ready drops after the 2nd word. Set out_ready[2]=1 -> 0xA0 then 0xA1 drain in order, then the 3rd word is accepted.
REQ-032 Lane isolation: lane 1 full and stalled; send to lane 3 -> accepted every cycle; lane 1 contents unchanged.
REQ-033 Simultaneous push and pop: lane 0 holding 1 word, out_ready[0]=1, push 0x5A -> occupancy stays 1 and 0x5A is the next head.
REQ-034 Reset mid-stream: lane 2 holding 2 words; assert rst for 1 cycle -> out_valid=0000 and in_ready=1 next cycle; the old words never appear.
REQ-035 DEMUX_CNT_EN: 300 transfers to lane 3 -> lane_cnt[31:24]=255 and the other lanes read 0; after rst all counters read 0.
